// File: rtl/exec_stim_gen.sv
// rtl/exec_stim_gen.sv - execute-stage stand-in answering IFD decodes with a new PC and an LFSR-timed stall
module exec_stim_gen #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          MIN_STALL  = 1,
  parameter int          MAX_STALL  = 20,
  parameter int          MAX_TRANS  = 50000,
  parameter int          CNT_WIDTH  = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  mem_op_any,
  input  logic                  op7_op_any,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] PC_value,
  output logic [CNT_WIDTH-1:0]  trans_count,
  output logic                  done
);

  localparam int                   RANGE    = MAX_STALL - MIN_STALL + 1;
  localparam int                   K        = $clog2(RANGE);
  localparam int                   SW       = $clog2(MAX_STALL + 1);
  localparam logic [15:0]          RAW_MASK = 16'((32'd1 << K) - 32'd1);
  localparam logic [15:0]          RANGE16  = 16'(RANGE);
  localparam logic [SW-1:0]        MIN_SW   = SW'(MIN_STALL);
  localparam logic [CNT_WIDTH-1:0] MAX_T    = CNT_WIDTH'(MAX_TRANS);

  typedef enum logic [2:0] {
    ST_WAIT_OP,
    ST_SETTLE,
    ST_STALL,
    ST_FINAL_SETTLE,
    ST_FINAL_STALL,
    ST_DONE
  } state_t;

  state_t                  state_q;
  logic [15:0]             lfsr_q;
  logic [15:0]             lfsr_d;
  logic                    op_q;
  logic                    stall_q;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [SW-1:0]           cnt_q;
  logic [CNT_WIDTH-1:0]    tc_q;
  logic                    done_q;

  logic [15:0]             raw_masked;
  logic [15:0]             raw_wrap;
  logic [SW-1:0]           stall_len;
  logic [ADDR_WIDTH-1:0]   cand;
  logic [ADDR_WIDTH-1:0]   pc_next;

  always_comb begin
    lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    raw_masked = lfsr_q & RAW_MASK;
    // raw < 2^K < 2*RANGE, so one conditional subtract folds it into range
    raw_wrap   = (raw_masked >= RANGE16) ? raw_masked - RANGE16 : raw_masked;
    stall_len  = (mode == 2'd2) ? MIN_SW : MIN_SW + SW'(raw_wrap);
    cand       = (mode == 2'd1) ? pc_q + ADDR_WIDTH'(1) : lfsr_q[ADDR_WIDTH-1:0];
    pc_next    = (cand == base_addr) ? cand + ADDR_WIDTH'(1) : cand;
  end

  // op_seen is registered once so that the load lands two edges after the sample
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_WAIT_OP;
      lfsr_q  <= LFSR_SEED;
      op_q    <= 1'b0;
      stall_q <= 1'b0;
      pc_q    <= '0;
      cnt_q   <= '0;
      tc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      op_q   <= mem_op_any | op7_op_any;
      case (state_q)
        ST_WAIT_OP: begin
          if (op_q && enable) begin
            state_q <= (tc_q == MAX_T) ? ST_FINAL_SETTLE : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          pc_q    <= pc_next;
          cnt_q   <= stall_len;
          stall_q <= 1'b1;
          state_q <= ST_STALL;
        end
        ST_STALL: begin
          if (cnt_q <= SW'(1)) begin
            stall_q <= 1'b0;
            tc_q    <= tc_q + CNT_WIDTH'(1);
            state_q <= ST_WAIT_OP;
          end else begin
            cnt_q <= cnt_q - SW'(1);
          end
        end
        ST_FINAL_SETTLE: begin
          pc_q    <= base_addr;
          cnt_q   <= stall_len;
          stall_q <= 1'b1;
          state_q <= ST_FINAL_STALL;
        end
        ST_FINAL_STALL: begin
          if (cnt_q <= SW'(1)) begin
            stall_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - SW'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_WAIT_OP;
        end
      endcase
    end
  end

  assign stall       = stall_q;
  assign PC_value    = pc_q;
  assign trans_count = tc_q;
  assign done        = done_q;

endmodule
